bpu_btb: RTL and testbench
==========================

# bpu_btb

Branch prediction unit feeding the PC register's `prdt_taken_i`/`prdt_addr_i` inputs: a direct-mapped branch target buffer with 2-bit saturating counters. It is looked up combinationally on the current PC and trained by the execute stage on every resolved branch or jump. A one-deep prediction pipeline register carries the prediction alongside the fetched instruction, so the decode/execute stages can detect mispredictions.

## Interface
- `ENTRIES`, 16: BTB depth; power of two, 4..256. `IDX_W = log2(ENTRIES)`.
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-low reset.
- `pc_i` input 32: current PC, i.e. the output of the PC register.
- `prdt_taken_o` output 1: predict taken for `pc_i` (combinational).
- `prdt_addr_o` output 32: predicted target (combinational); 0 when `prdt_taken_o`=0.
- `upd_valid_i` input 1: execute stage resolved a branch/jal this cycle.
- `upd_pc_i` input 32: PC of the resolved instruction.
- `upd_taken_i` input 1: actual direction.
- `upd_target_i` input 32: actual taken target.
- `flush_i` input 1: invalidate the whole table (fence.i, jtag reset).
- `jump_flag_i` input 1: redirect from execute; kills the in-flight prediction.
- `stall_flag_i` input 1: fetch stall.
- `hold_flag_i` input `Hold_Flag_Bus`: pipeline hold; the PC is held when `hold_flag_i >= Hold_Pc`.
- `prdt_taken_q_o` output 1: prediction aligned with the fetched instruction.
- `prdt_addr_q_o` output 32: target aligned with the fetched instruction.

## Operation
- Address split: index = `pc[IDX_W+1:2]`, tag = `pc[31:IDX_W+2]`. Bits [1:0] are ignored.
- Entry fields: `valid` (1 bit), tag, target (32 bits), `ctr` (2 bits).
- Lookup:
  - hit = `valid[idx] && tag[idx]==tag(pc_i)`.
  - `prdt_taken_o` = hit & `ctr[1]`.
  - `prdt_addr_o` = target when `prdt_taken_o`=1, else 0.
- Update, on a clock edge with `upd_valid_i`=1:
  - Hit: `ctr` saturating +1 if taken, -1 if not taken (stops at 3 and 0). When taken, target is overwritten with `upd_target_i`.
  - Miss and taken: allocate or replace. `valid`=1, tag written, target=`upd_target_i`, `ctr`=2'b10.
  - Miss and not taken: no change.
- Flush: `flush_i`=1 clears all `valid` bits on that edge. It overrides a same-cycle update, which is dropped.
- Prediction pipeline register, in priority order:
  1. `jump_flag_i`=1: cleared to 0/0.
  2. Stall (`stall_flag_i` or `hold_flag_i >= Hold_Pc`): hold value.
  3. Otherwise: capture `prdt_taken_o`/`prdt_addr_o`.

## Timing
- Reset (async assert, `rst`=0):
  - all `valid`=0, all `ctr`=2'b01;
  - `prdt_taken_q_o`=0, `prdt_addr_q_o`=0;
  - combinational outputs therefore read 0/0.
- Tag and target storage need no reset.
- Reset deasserts synchronously to `clk`; the first update is accepted on the first edge with `rst`=1.
- Lookup latency is 0 cycles: combinational from `pc_i`, with no path from the `upd_*` inputs.
- Update latency is 1 cycle: written at edge N, visible to lookups from cycle N+1.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents.
- Back-to-back updates to the same index apply in order, one per edge.
- Pipeline register latency is 1 cycle: the `_q` outputs in cycle N+1 reflect the lookup of `pc_i` in cycle N, unless stalled or killed.
- Reset asserted mid-operation: the table is invalidated immediately. Any update on that edge is lost.

## Test plan
- After reset, `pc_i`=0x0000_0100 gives `prdt_taken_o`=0 and `prdt_addr_o`=0. `_q` outputs read 0 after one clock.
- Allocate: one edge with `upd_valid_i`=1, pc=0x100, taken=1, target=0x80. Next cycle, `pc_i`=0x100 gives taken=1, addr=0x80.
- Hysteresis on entry 0x100, from `ctr`=10:
  - two taken updates take `ctr` to 11 and it stays at 11;
  - three not-taken updates take it 10 → 01 (prediction becomes not taken) → 00;
  - one taken update gives 01, still not taken.
- Alias with `ENTRIES`=16: 0x100 is allocated.
  - `pc_i`=0x140 (same index, different tag) gives taken=0.
  - A taken update at 0x140 with target 0x200 evicts the entry; 0x100 then misses.
- Flush and collision:
  - with 0x100 allocated, `flush_i`=1 together with a taken update at 0x104: next cycle both 0x100 and 0x104 miss.
  - same-cycle lookup/update of 0x100 returns the old value.
- Pipeline register:
  - lookup taken/0x80, then `stall_flag_i`=1 for 3 cycles: `_q` holds 1/0x80;
  - `jump_flag_i`=1: next cycle `_q`=0/0, which takes priority over a simultaneous stall;
  - drop `rst` mid-update: `_q` goes to 0 immediately and the table misses afterwards.

Source files
------------

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit counters: 0-cycle lookup, updates visible next cycle.
// Prediction register follows fetch: a jump clears it, a stall or hold freezes it.
module bpu_btb #(
  parameter int                 ENTRIES = 16,
  parameter int                 HOLD_W  = 3,
  parameter logic [HOLD_W-1:0]  HOLD_PC = HOLD_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  output logic              prdt_taken_o,
  output logic [31:0]       prdt_addr_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [31:0]       upd_target_i,
  input  logic              flush_i,
  input  logic              jump_flag_i,
  input  logic              stall_flag_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  output logic              prdt_taken_q_o,
  output logic [31:0]       prdt_addr_q_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [1:0]       up_ctr, up_ctr_d;
  logic             up_wr_tgt;

  // Instruction-alignment bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[31:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[31:IDX_W+2];

  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign prdt_taken_o = lk_hit && ctr_q[lk_idx][1];
  assign prdt_addr_o  = prdt_taken_o ? tgt_q[lk_idx] : 32'h0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  always_comb begin
    up_ctr_d = up_ctr;
    if (upd_taken_i) begin
      if (up_ctr != 2'b11) up_ctr_d = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'b00) up_ctr_d = up_ctr - 2'd1;
    end
  end

  // Any accepted taken update writes tag and target: on a hit the tag is unchanged.
  assign up_wr_tgt = upd_valid_i && !flush_i && upd_taken_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_d;
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (up_wr_tgt) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target_i;
    end
  end

  logic        prdt_taken_q, prdt_taken_d;
  logic [31:0] prdt_addr_q, prdt_addr_d;
  logic        stall;

  assign stall = stall_flag_i || (hold_flag_i >= HOLD_PC);

  always_comb begin
    prdt_taken_d = prdt_taken_q;
    prdt_addr_d  = prdt_addr_q;
    if (jump_flag_i) begin
      prdt_taken_d = 1'b0;
      prdt_addr_d  = 32'h0;
    end else if (!stall) begin
      prdt_taken_d = prdt_taken_o;
      prdt_addr_d  = prdt_addr_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prdt_taken_q <= 1'b0;
      prdt_addr_q  <= 32'h0;
    end else begin
      prdt_taken_q <= prdt_taken_d;
      prdt_addr_q  <= prdt_addr_d;
    end
  end

  assign prdt_taken_q_o = prdt_taken_q;
  assign prdt_addr_q_o  = prdt_addr_q;

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb with ENTRIES=16 (index pc[5:2], tag pc[31:6]).
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        prdt_taken_o;
  logic [31:0] prdt_addr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        flush_i;
  logic        jump_flag_i;
  logic        stall_flag_i;
  logic [2:0]  hold_flag_i;
  logic        prdt_taken_q_o;
  logic [31:0] prdt_addr_q_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bpu_btb #(.ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .prdt_taken_o   (prdt_taken_o),
    .prdt_addr_o    (prdt_addr_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i),
    .flush_i        (flush_i),
    .jump_flag_i    (jump_flag_i),
    .stall_flag_i   (stall_flag_i),
    .hold_flag_i    (hold_flag_i),
    .prdt_taken_q_o (prdt_taken_q_o),
    .prdt_addr_q_o  (prdt_addr_q_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tg);
    upd_valid_i  = 1'b1;
    upd_pc_i     = p;
    upd_taken_i  = t;
    upd_target_i = tg;
    cyc();
    upd_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_i = 32'h100;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    flush_i = 1'b0; jump_flag_i = 1'b0; stall_flag_i = 1'b0; hold_flag_i = 3'd0;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_lookup: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
    n_cmp++;
    if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_q: got %b/%h want 0/0", prdt_taken_q_o, prdt_addr_q_o);
    end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    n_cmp++;
    if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_q_after_clk: got %b/%h want 0/0", prdt_taken_q_o, prdt_addr_q_o);
    end
  endtask

  task automatic test_allocate();
    pc_i = 32'h100;
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_target_i = 32'h80;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL same_cycle_alloc: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
    cyc();
    upd_valid_i = 1'b0;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL alloc_hit: got %b/%h want 1/00000080", prdt_taken_o, prdt_addr_o);
    end
  endtask

  task automatic test_hysteresis();
    logic [0:8]  tk;
    logic [0:8]  pr;
    logic [31:0] tg [9];
    logic [31:0] ea;
    tk = 9'b111_0000_11;
    pr = 9'b111_1000_01;
    tg = '{32'h80, 32'h80, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h84, 32'h90};
    pc_i = 32'h100;
    for (int i = 0; i < 9; i++) begin
      upd(32'h100, tk[i], tg[i]);
      ea = pr[i] ? ((i == 8) ? 32'h90 : 32'h80) : 32'h0;
      n_cmp++;
      if ({prdt_taken_o, prdt_addr_o} !== {pr[i], ea}) begin
        n_err++;
        $display("FAIL hyst_step%0d: got %b/%h want %b/%h", i, prdt_taken_o, prdt_addr_o, pr[i], ea);
      end
    end
  endtask

  task automatic test_alias();
    pc_i = 32'h140;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL alias_miss: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
    upd(32'h140, 1'b1, 32'h200);
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL alias_evict_hit: got %b/%h want 1/00000200", prdt_taken_o, prdt_addr_o);
    end
    pc_i = 32'h100;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL alias_old_miss: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
    // Not-taken miss on an aliasing PC must leave the resident entry alone.
    upd(32'h108, 1'b1, 32'h400);
    upd(32'h148, 1'b0, 32'h0);
    pc_i = 32'h108;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b1, 32'h400}) begin
      n_err++; $display("FAIL nt_miss_nochange: got %b/%h want 1/00000400", prdt_taken_o, prdt_addr_o);
    end
  endtask

  task automatic test_flush();
    upd(32'h100, 1'b1, 32'h80);
    pc_i = 32'h100;
    flush_i = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b1; upd_target_i = 32'h300;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL flush_pre_edge: got %b/%h want 1/00000080", prdt_taken_o, prdt_addr_o);
    end
    cyc();
    flush_i = 1'b0; upd_valid_i = 1'b0;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL flush_0x100: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
    pc_i = 32'h104;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL flush_0x104: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
  endtask

  task automatic test_pipeline();
    upd(32'h100, 1'b1, 32'h80);
    pc_i = 32'h100;
    cyc();
    n_cmp++;
    if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL pipe_capture: got %b/%h want 1/00000080", prdt_taken_q_o, prdt_addr_q_o);
    end
    pc_i = 32'h0;
    stall_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b1, 32'h80}) begin
        n_err++; $display("FAIL pipe_stall%0d: got %b/%h want 1/00000080", i, prdt_taken_q_o, prdt_addr_q_o);
      end
    end
    stall_flag_i = 1'b0;
    hold_flag_i = 3'd1;
    cyc();
    n_cmp++;
    if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL pipe_hold: got %b/%h want 1/00000080", prdt_taken_q_o, prdt_addr_q_o);
    end
    hold_flag_i = 3'd0;
    cyc();
    n_cmp++;
    if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL pipe_release: got %b/%h want 0/0", prdt_taken_q_o, prdt_addr_q_o);
    end
    pc_i = 32'h100;
    cyc();
    jump_flag_i = 1'b1; stall_flag_i = 1'b1;
    cyc();
    jump_flag_i = 1'b0; stall_flag_i = 1'b0;
    n_cmp++;
    if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL pipe_jump_kill: got %b/%h want 0/0", prdt_taken_q_o, prdt_addr_q_o);
    end
  endtask

  task automatic test_reset_mid();
    pc_i = 32'h100;
    cyc();
    upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b1; upd_target_i = 32'h500;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({prdt_taken_q_o, prdt_addr_q_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL rstmid_q: got %b/%h want 0/0", prdt_taken_q_o, prdt_addr_q_o);
    end
    cyc();
    upd_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL rstmid_0x100: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
    pc_i = 32'h104;
    #1;
    n_cmp++;
    if ({prdt_taken_o, prdt_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL rstmid_upd_lost: got %b/%h want 0/0", prdt_taken_o, prdt_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_flush();
    test_pipeline();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
